// File: rtl/mpy_div_seq.sv
// mpy_div_seq: multi-cycle signed multiply / divide sequencer for the integer
// datapath. One request is captured, iterated 32 times on operand magnitudes in
// a 64-bit working register, sign-corrected, and committed to HI/LO.
module mpy_div_seq #(
  parameter logic [4:0] FS_MUL = 5'h1E,
  parameter logic [4:0] FS_DIV = 5'h1F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  FS,
  input  logic [31:0] S,
  input  logic [31:0] T,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Two's complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    neg64 = ~v + 64'd1;
  endfunction

  // Architectural and sequencing state
  logic [1:0]  state_r;
  logic [5:0]  count_r;
  logic        op_div_r;
  logic        neg_main_r;   // sign of product or quotient
  logic        neg_rem_r;    // remainder sign follows the dividend
  logic [31:0] mag_t_r;      // multiplicand (MUL) or divisor (DIV) magnitude
  logic [63:0] work_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        busy_r;
  logic        done_r;
  logic        dbz_r;

  // Combinational next-state and datapath signals
  logic        can_accept_s;
  logic        is_mul_s;
  logic        is_div_s;
  logic        t_zero_s;
  logic        load_s;
  logic        dbz_hit_s;
  logic [1:0]  next_state_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_top_s;
  logic [32:0] div_diff_s;
  logic [63:0] div_next_s;
  logic [63:0] step_next_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;

  // Request decode: only IDLE and DONE may accept a new operation
  always_comb begin
    can_accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    is_mul_s     = (FS == FS_MUL);
    is_div_s     = (FS == FS_DIV);
    t_zero_s     = (T == 32'd0);
    load_s       = can_accept_s && (is_mul_s || (is_div_s && !t_zero_s));
    dbz_hit_s    = can_accept_s && is_div_s && t_zero_s;
  end

  // One radix-2 iteration: shift-add for MUL, restoring shift-subtract for DIV
  always_comb begin
    mul_sum_s  = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, mag_t_r} : 33'd0);
    mul_next_s = {mul_sum_s, work_r[31:1]};
    div_top_s  = work_r[63:31];
    div_diff_s = div_top_s - {1'b0, mag_t_r};
    if (!div_diff_s[32]) begin
      div_next_s = {div_diff_s[31:0], work_r[30:0], 1'b1};
    end else begin
      div_next_s = {div_top_s[31:0], work_r[30:0], 1'b0};
    end
    if (op_div_r) begin
      step_next_s = div_next_s;
    end else begin
      step_next_s = mul_next_s;
    end
  end

  // Sign correction of the finished magnitude result
  always_comb begin
    if (neg_main_r) begin
      prod_fix_s = neg64(work_r);
      quo_fix_s  = neg32(work_r[31:0]);
    end else begin
      prod_fix_s = work_r;
      quo_fix_s  = work_r[31:0];
    end
    if (neg_rem_r) begin
      rem_fix_s = neg32(work_r[63:32]);
    end else begin
      rem_fix_s = work_r[63:32];
    end
  end

  // Sequencer next-state selection
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (load_s) begin
          next_state_s = ST_RUN;
        end else if (dbz_hit_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (count_r == 6'd31) begin
          next_state_s = ST_FIX;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_FIX:  next_state_s = ST_DONE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= 6'd0;
      op_div_r   <= 1'b0;
      neg_main_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      mag_t_r    <= 32'd0;
      work_r     <= 64'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      dbz_r      <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_RUN) || (next_state_s == ST_FIX);
      done_r  <= (next_state_s == ST_DONE);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          dbz_r <= dbz_hit_s;
          if (load_s) begin
            op_div_r   <= is_div_s;
            neg_main_r <= S[31] ^ T[31];
            neg_rem_r  <= S[31];
            count_r    <= 6'd0;
            if (is_div_s) begin
              mag_t_r <= abs32(T);
              work_r  <= {32'd0, abs32(S)};
            end else begin
              mag_t_r <= abs32(S);
              work_r  <= {32'd0, abs32(T)};
            end
          end
        end
        ST_RUN: begin
          work_r  <= step_next_s;
          count_r <= count_r + 6'd1;
        end
        ST_FIX: begin
          dbz_r <= 1'b0;
          if (op_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            hi_r <= prod_fix_s[63:32];
            lo_r <= prod_fix_s[31:0];
          end
        end
        default: dbz_r <= 1'b0;
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign HI          = hi_r;
  assign LO          = lo_r;

endmodule

// File: tb/tb_mpy_div_seq.sv
// tb_mpy_div_seq: directed self-checking bench for mpy_div_seq with
// hand-computed expected HI/LO values and latency counts.
module tb_mpy_div_seq;

  localparam logic [4:0] FS_MUL = 5'h1E;
  localparam logic [4:0] FS_DIV = 5'h1F;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  FS;
  logic [31:0] S;
  logic [31:0] T;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;
  int lat;
  int bc;
  int dn;

  always #5 clk = ~clk;

  mpy_div_seq #(.FS_MUL(FS_MUL), .FS_DIV(FS_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .FS          (FS),
    .S           (S),
    .T           (T),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .HI          (HI),
    .LO          (LO)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; start is seen by the next rising edge (E0).
  task automatic issue(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
    FS    = fs;
    S     = s;
    T     = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (done !== 1'b1 && l < 100) begin
      if (busy === 1'b1) b++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] fs, input logic [31:0] s,
                        input logic [31:0] t, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int l;
    int b;
    issue(fs, s, t);
    wait_done(l, b);
    check_eq({tag, "_lat"}, 64'(l), 64'd33);
    check_eq({tag, "_hi"},  64'(HI), 64'(exp_hi));
    check_eq({tag, "_lo"},  64'(LO), 64'(exp_lo));
    check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    FS    = 5'd0;
    S     = 32'd0;
    T     = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dbz",  64'(div_by_zero), 64'd0);
    check_eq("rst_hi",   64'(HI), 64'd0);
    check_eq("rst_lo",   64'(LO), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // -2 * 3 = -6
    issue(FS_MUL, 32'hFFFF_FFFE, 32'd3);
    check_eq("mul1_busy0", 64'(busy), 64'd1);
    wait_done(lat, bc);
    check_eq("mul1_lat",  64'(lat), 64'd33);
    check_eq("mul1_bcyc", 64'(bc), 64'd33);
    check_eq("mul1_busy", 64'(busy), 64'd0);
    check_eq("mul1_hi",   64'(HI), 64'hFFFF_FFFF);
    check_eq("mul1_lo",   64'(LO), 64'hFFFF_FFFA);
    check_eq("mul1_dbz",  64'(div_by_zero), 64'd0);
    @(negedge clk);
    check_eq("mul1_pulse", 64'(done), 64'd0);

    // -7 / 2 = -3 rem -1
    run_op("div1", FS_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(negedge clk);

    // Divide by zero: done in the cycle after accept, HI/LO untouched
    issue(FS_DIV, 32'd5, 32'd0);
    check_eq("dbz_done", 64'(done), 64'd1);
    check_eq("dbz_flag", 64'(div_by_zero), 64'd1);
    check_eq("dbz_busy", 64'(busy), 64'd0);
    check_eq("dbz_hi",   64'(HI), 64'hFFFF_FFFF);
    check_eq("dbz_lo",   64'(LO), 64'hFFFF_FFFD);
    @(negedge clk);
    check_eq("dbz_done_clr", 64'(done), 64'd0);
    check_eq("dbz_flag_clr", 64'(div_by_zero), 64'd0);

    // Most-negative operand corners
    run_op("mul_min", FS_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    @(negedge clk);
    run_op("div_ovf", FS_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    @(negedge clk);

    // start mid-operation is ignored; operand changes after accept have no effect
    issue(FS_MUL, 32'h1234_5678, 32'h0000_0100);
    repeat (4) @(negedge clk);
    check_eq("hold_lo",   64'(LO), 64'h8000_0000);
    check_eq("hold_busy", 64'(busy), 64'd1);
    FS    = FS_DIV;
    S     = 32'd7;
    T     = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    S     = 32'd0;
    T     = 32'd0;
    wait_done(lat, bc);
    check_eq("ign_lat", 64'(lat), 64'd28);
    check_eq("ign_hi",  64'(HI), 64'h0000_0012);
    check_eq("ign_lo",  64'(LO), 64'h3456_7800);

    // Back-to-back: accepted during the DONE cycle; 100 / -7 = -14 rem 2
    run_op("b2b", FS_DIV, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
    @(negedge clk);
    check_eq("b2b_pulse", 64'(done), 64'd0);

    // Unknown function select is ignored
    issue(5'h00, 32'd3, 32'd4);
    check_eq("bad_fs_busy", 64'(busy), 64'd0);
    check_eq("bad_fs_done", 64'(done), 64'd0);
    check_eq("bad_fs_hi",   64'(HI), 64'h0000_0002);

    // Reset in the middle of a divide aborts immediately
    issue(FS_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_hi",   64'(HI), 64'd0);
    check_eq("abort_lo",   64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    check_eq("abort_no_done", 64'(dn), 64'd0);
    check_eq("abort_idle",    64'(busy), 64'd0);

    // Recovery and remaining sign combinations
    run_op("mul_nn", FS_MUL, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0023);
    @(negedge clk);
    run_op("div_nn", FS_DIV, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0002);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
